// File: rtl/sample_framer.sv
// Frames a continuous ADC sample stream into FRAME_LEN-sample blocks for the FFT buffer,
// then hands off to the FFT core. Optional macro SAMPLE_FRAMER_BITREV_EN writes bit-reversed addresses.
module sample_framer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 512,
  parameter int LOG2_LEN  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_valid,
  input  logic              fft_done,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] address,
  output logic              sram_write_ena,
  output logic              fft_start,
  output logic              busy,
  output logic [15:0]       overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [LOG2_LEN-1:0] LAST_PTR = LOG2_LEN'(FRAME_LEN - 1);

  state_t              state;
  logic [LOG2_LEN-1:0] wr_ptr;

  // Drop counter holds at all-ones rather than wrapping back to a misleading small value.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] map_addr(input logic [LOG2_LEN-1:0] p);
    logic [LOG2_LEN-1:0] r;
`ifdef SAMPLE_FRAMER_BITREV_EN
    for (int b = 0; b < LOG2_LEN; b++) r[b] = p[LOG2_LEN-1-b];
`else
    r = p;
`endif
    return ADDR_W'(r);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      write_data     <= '0;
      address        <= '0;
      sram_write_ena <= 1'b0;
      fft_start      <= 1'b0;
      busy           <= 1'b0;
      overrun_cnt    <= '0;
    end else begin
      sram_write_ena <= 1'b0;
      fft_start      <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state  <= FILL;
            wr_ptr <= '0;
          end
        end
        FILL: begin
          if (in_valid) begin
            // The sample is written even if run drops in the same cycle.
            write_data     <= in_sample;
            address        <= map_addr(wr_ptr);
            sram_write_ena <= 1'b1;
            if (wr_ptr == LAST_PTR) begin
              state  <= START;
              wr_ptr <= '0;
            end else if (!run) begin
              state  <= IDLE;
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end else if (!run) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end
        end
        START: begin
          fft_start <= 1'b1;
          busy      <= 1'b1;
          state     <= WAIT_DONE;
          if (in_valid) overrun_cnt <= sat_inc(overrun_cnt);
        end
        WAIT_DONE: begin
          // No backpressure upstream: anything arriving now is lost, including a sample alongside fft_done.
          if (in_valid) overrun_cnt <= sat_inc(overrun_cnt);
          if (fft_done) begin
            busy   <= 1'b0;
            wr_ptr <= '0;
            state  <= run ? FILL : IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          wr_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Upstream stage of the FFT sample buffer (mem_buff).
- Accepts a continuous stream of 16-bit ADC samples. Packs each FRAME_LEN run of samples into the buffer through its write port (write_data / address / sram_write_ena).
- After the last write of a frame, pulses fft_start, then holds off until the FFT core reports completion.
- While the FFT is busy, incoming samples are dropped and counted, because the input stream has no backpressure.

Parameters:
- DATA_W, 16, sample width; matches buffer write_data.
- ADDR_W, 10, buffer address width.
- FRAME_LEN, 512, samples per frame; must be a power of two and ≤ 2^ADDR_W.
- LOG2_LEN, 9, log2(FRAME_LEN); used for address reversal.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-high reset.
- run, input, 1, level enable for framing.
- in_sample, input, DATA_W, incoming sample.
- in_valid, input, 1, in_sample valid this cycle; no ready/backpressure.
- fft_done, input, 1, single-cycle pulse from the FFT core: the frame has been consumed.
- write_data, output, DATA_W, buffer write data (registered).
- address, output, ADDR_W, buffer write address (registered).
- sram_write_ena, output, 1, buffer write strobe, one cycle per sample (registered).
- fft_start, output, 1, single-cycle pulse: frame complete (registered).
- busy, output, 1, high in WAIT_DONE.
- overrun_cnt, output, 16, saturating count of dropped samples.

Behaviour:
- One clock domain; reset is synchronous, active-high (rst sampled on the rising edge of clk).
- Reset values:
  - state = IDLE, wr_ptr = 0.
  - write_data = 0, address = 0, sram_write_ena = 0, fft_start = 0, busy = 0, overrun_cnt = 0.
  - rst wins over every other input in the same cycle. Reset mid-frame discards the partial frame without issuing fft_start.
- States: IDLE, FILL, START, WAIT_DONE.
- IDLE:
  - Outputs quiet; in_valid ignored, not counted.
  - run = 1 → FILL with wr_ptr = 0.
- FILL, in a cycle with in_valid = 1:
  - Next edge: write_data <= in_sample, address <= wr_ptr (zero-extended to ADDR_W), sram_write_ena <= 1.
  - wr_ptr increments. Latency is one cycle from in_valid to strobe.
  - Back-to-back valids give back-to-back strobes.
  - in_valid = 0 → sram_write_ena <= 0; write_data and address hold.
  - Accepted write with wr_ptr = FRAME_LEN-1 → START, wr_ptr wraps to 0.
  - run = 0 in FILL (and no last-sample write that cycle) → IDLE, wr_ptr = 0, partial frame abandoned. A cycle that has in_valid = 1 and run = 0 still performs that sample's write.
- START:
  - Entered on the edge that raises the final sram_write_ena.
  - On the next edge: fft_start <= 1 for exactly one cycle, sram_write_ena <= 0, busy <= 1; → WAIT_DONE.
  - fft_start therefore rises the cycle after the final write strobe.
  - in_valid during START is dropped and counted.
- WAIT_DONE:
  - busy = 1; every in_valid increments overrun_cnt. overrun_cnt saturates at 16'hFFFF and never wraps.
  - fft_done = 1 → FILL if run = 1, else IDLE; busy <= 0 on the same edge.
  - A sample arriving with fft_done in the same cycle is dropped and counted; the first accepted sample is the one in the cycle after.
  - run = 0 does not abort WAIT_DONE.
- fft_done outside WAIT_DONE is ignored.
- overrun_cnt clears only on rst.
- sram_write_ena and fft_start are never high in the same cycle.

Optional Feature:
- Macro: SAMPLE_FRAMER_BITREV_EN.
- Defined: the written address is the LOG2_LEN-bit bit-reversal of wr_ptr, zero-extended to ADDR_W. The buffer then holds the frame in bit-reversed order for an in-place decimation-in-time FFT. wr_ptr sequencing, timing and strobes are unchanged.
- Undefined: address = wr_ptr (natural order).

Test Plan:
- Reset then run = 1; 512 consecutive valids with in_sample = i+100 → 512 strobes at addresses 0..511 with write_data = i+100; fft_start pulses once, the cycle after strobe 511; busy = 1 the following cycle.
- In WAIT_DONE, 5 valids, then fft_done together with a 6th valid → overrun_cnt = 6. The next valid writes address 0.
- Gapped input (valid every 3rd cycle) for a full frame → exactly 512 strobes, addresses contiguous, no strobe on idle cycles.
- run dropped after 200 accepted samples → IDLE, no fft_start. Re-raising run and writing a frame restarts at address 0.
- rst asserted in WAIT_DONE → all outputs zero next cycle, overrun_cnt = 0, state IDLE.
- With SAMPLE_FRAMER_BITREV_EN: samples 0,1,2,3 → addresses 0, 256, 128, 384; sample 511 → address 511.
- Saturation: force 65,540 drops (hold valid through a long WAIT_DONE) → overrun_cnt = 16'hFFFF.
